truth_table_prober: RTL
=======================

TRUTH_TABLE_PROBER -- requirements
Module: truth_table_prober

Interface
REQ-001 Parameter SETTLE, default 2: cycles held per input vector before sampling; legal range 1..255.
REQ-002 Parameter EXPECTED, default 8'h8E: golden 3-input truth table compared against the measured table.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  sweep request; sampled only in IDLE.
REQ-006 probe_in1, probe_in2, probe_in3  output  1 each  drive the gate under test as vector {in1,in2,in3}.
REQ-007 probe_out  input  1  gate-under-test output.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 table  output  8  measured truth table; bit (7-idx) = probe_out sampled at vector idx = {in1,in2,in3}.
REQ-011 match  output  1  high when table == EXPECTED after a completed sweep.

Function
REQ-012 States: IDLE, APPLY, SAMPLE, DONE; 3-bit vector index idx; 8-bit settle counter.
REQ-013 IDLE with start=1 at edge T0: clear table and match, set idx=0, enter APPLY; busy=1 and probes={0,0,0} from T0+1.
REQ-014 APPLY: probes = idx; hold for SETTLE cycles counted from entry, then enter SAMPLE.
REQ-015 SAMPLE (1 cycle): capture probe_out into table bit (7-idx); if idx<7, increment idx and return to APPLY; if idx=7, enter DONE.
REQ-016 Each vector window lasts exactly SETTLE+1 cycles; probe outputs change only on window boundaries.
REQ-017 DONE (1 cycle): done=1, busy=0, match=(table==EXPECTED), probes={0,0,0}; next state IDLE.
REQ-018 With SETTLE=2 and no sync stage, done is high in cycle T0+1+8*(SETTLE+1) = T0+25.
REQ-019 table and match hold their values in IDLE until the next accepted start.
REQ-020 start during APPLY, SAMPLE or DONE is ignored; it is not queued.
REQ-021 idx wrap from 7 to 0 never occurs within a sweep; the sweep terminates at idx=7.
REQ-022 The block is purely observational: probe_out is never used combinationally to drive any output.

Reset
REQ-023 rst=1 forces immediately, regardless of clk: state=IDLE, idx=0, settle counter=0, probes={0,0,0}, busy=0, done=0, table=8'h00, match=0.
REQ-024 Reset mid-sweep discards partial results; no done pulse is produced for the aborted sweep.
REQ-025 The first start is honoured on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro PROBE_SYNC_EN defined: probe_out passes through a two-flop synchronizer (reset to 0) before capture, and each APPLY phase lasts SETTLE+2 cycles, so every window is SETTLE+3 cycles.
REQ-027 Macro PROBE_SYNC_EN undefined: probe_out is captured directly, and windows are SETTLE+1 cycles as in REQ-016.

Verification
REQ-028 SETTLE=2, gate model implements 0x8E, start pulse at T0 -> probes step through 000..111, done at T0+25, table=8'h8E, match=1.
REQ-029 Gate model stuck at 0 -> table=8'h00, match=0; stuck at 1 -> table=8'hFF, match=0.
REQ-030 start held high for the entire sweep -> exactly one sweep, one done pulse, busy drops in the DONE cycle, and a new sweep begins the cycle after DONE only if start is still high in IDLE.
REQ-031 rst asserted while idx=4 -> same cycle probes=000, busy=0, table=8'h00, and no done pulse follows.
REQ-032 PROBE_SYNC_EN defined, SETTLE=2, gate model 0x8E -> done at T0+1+8*5 = T0+41, table=8'h8E, match=1.
REQ-033 Gate model 0x8E with bit idx=5 flipped -> table=8'h8A, match=0, and the table persists unchanged through 20 idle cycles.

Source files
------------

// File: rtl/truth_table_prober.sv
// Sweeps all 8 input vectors of a 3-input gate, records its truth table and compares it to EXPECTED.
// Optional macro PROBE_SYNC_EN adds a 2-flop synchronizer on probe_out; the measured table port is meas_table.
module truth_table_prober #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'h8E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       probe_in1,
  output logic       probe_in2,
  output logic       probe_in3,
  input  logic       probe_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] meas_table,
  output logic       match
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } state_t;

`ifdef PROBE_SYNC_EN
  // Two extra APPLY cycles cover the synchronizer latency; 9 bits keeps SETTLE=255 representable.
  localparam int unsigned APPLY_CYCLES = SETTLE + 2;
  localparam int unsigned CNT_W        = 9;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sample_bit;

  always_comb begin
    sync1_d = probe_out;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample_bit = sync2_q;
`else
  localparam int unsigned APPLY_CYCLES = SETTLE;
  localparam int unsigned CNT_W        = 8;

  logic sample_bit;
  assign sample_bit = probe_out;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(APPLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       table_q, table_d;
  logic             match_q, match_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      table_q <= 8'h00;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          cnt_d   = '0;
          table_d = 8'h00;
          match_d = 1'b0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        // Vector idx lands in bit (7-idx), i.e. the bitwise inverse of idx.
        table_d[~idx_q] = sample_bit;
        if (idx_q == 3'd7) begin
          match_d = (table_d == EXPECTED);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    done = (state_q == ST_DONE);
    {probe_in1, probe_in2, probe_in3} = busy ? idx_q : 3'b000;
    meas_table = table_q;
    match      = match_q;
  end

endmodule
